// File: rtl/enemy_ai_ctrl_pkg.sv
// ============================================================================
// Module      : enemy_ai_ctrl_pkg
// Description : Shared types, default constants and the LFSR step function
//               for the enemy AI controller and its helpers.
//               Contents: ai_state_t decision-FSM states, default tuning
//               constants, lfsr_next() Galois step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package enemy_ai_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    APPROACH = 3'd1,
    RETREAT  = 3'd2,
    GUARD    = 3'd3,
    SQUAT    = 3'd4,
    JUMP     = 3'd5,
    COOLDOWN = 3'd6
  } ai_state_t;

  localparam int unsigned NEAR_DX_DEF         = 120;
  localparam int unsigned FAR_DX_DEF          = 320;
  localparam int unsigned DECIDE_PERIOD_DEF   = 8;
  localparam int unsigned GUARD_CYCLES_DEF    = 12;
  localparam int unsigned SQUAT_CYCLES_DEF    = 10;
  localparam int unsigned COOLDOWN_CYCLES_DEF = 6;
  localparam logic [3:0]  AGGRESSION_DEF      = 4'd8;
  localparam logic [15:0] LFSR_SEED_DEF       = 16'hACE1;
  localparam logic [15:0] LFSR_MASK           = 16'hB400;
  // Cycles after the jump pulse in which the airborne flag must appear.
  localparam int unsigned JUMP_RISE_TIMEOUT   = 3;

  // One Galois right-shift step: the bit shifted out folds the mask back in.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ai_lfsr16.sv
// ============================================================================
// Module      : ai_lfsr16
// Description : Free-running 16-bit Galois LFSR, reusable random source.
//   clk   in  1   clock
//   rst_n in  1   async active-low reset, loads SEED
//   q_o   out 16  current LFSR value
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ai_lfsr16
  import enemy_ai_ctrl_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q_o
);

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign q_o = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/enemy_ai_ctrl.sv
// ============================================================================
// Module      : enemy_ai_ctrl
// Description : Enemy opponent decision logic. Moore FSM plus LFSR choosing
//               approach / retreat / guard / squat / jump each frame.
//   clk          in  1   frame clock
//   rst_n        in  1   async active-low reset
//   en_i         in  1   game running; low forces IDLE and zero outputs
//   player_x_i   in  11  player x (signed)
//   player_atk_i in  1   player attack active
//   enemy_x_i    in  11  enemy x (signed)
//   enemy_isJ_i  in  1   enemy airborne
//   right_o/left_o      movement levels
//   jump_o              one-cycle jump request
//   squat_o/defend_o    hold levels
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module enemy_ai_ctrl
  import enemy_ai_ctrl_pkg::*;
#(
  parameter int unsigned NEAR_DX         = NEAR_DX_DEF,
  parameter int unsigned FAR_DX          = FAR_DX_DEF,
  parameter int unsigned DECIDE_PERIOD   = DECIDE_PERIOD_DEF,
  parameter int unsigned GUARD_CYCLES    = GUARD_CYCLES_DEF,
  parameter int unsigned SQUAT_CYCLES    = SQUAT_CYCLES_DEF,
  parameter int unsigned COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF,
  parameter logic [3:0]  AGGRESSION      = AGGRESSION_DEF,
  parameter logic [15:0] LFSR_SEED       = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic [10:0] player_x_i,
  input  logic        player_atk_i,
  input  logic [10:0] enemy_x_i,
  input  logic        enemy_isJ_i,
  output logic        right_o,
  output logic        left_o,
  output logic        jump_o,
  output logic        squat_o,
  output logic        defend_o
);

  localparam int unsigned     DEC_W    = $clog2(DECIDE_PERIOD);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIDE_PERIOD - 1);
  localparam logic [7:0]  GUARD_LAST = 8'(GUARD_CYCLES - 1);
  localparam logic [7:0]  SQUAT_LAST = 8'(SQUAT_CYCLES - 1);
  localparam logic [7:0]  COOL_LAST  = 8'(COOLDOWN_CYCLES - 1);
  localparam logic [7:0]  JUMP_LAST  = 8'(JUMP_RISE_TIMEOUT);
  localparam logic [11:0] NEAR_C     = 12'(NEAR_DX);
  localparam logic [11:0] FAR_C      = 12'(FAR_DX);
  localparam logic [11:0] ADX_MAX    = 12'd2047;

  ai_state_t         state_q, state_d;
  logic [7:0]        hold_q, hold_d;
  logic              jseen_q, jseen_d;
  logic [DEC_W-1:0]  dec_cnt_q, dec_cnt_d;
  logic              right_d, left_d, jump_d, squat_d, defend_d;
  logic              right_q, left_q, jump_q, squat_q, defend_q;

  logic [15:0]       rnd;
  logic signed [11:0] dx;
  logic [11:0]       adx_raw, adx;
  logic              tick, threat, aggressive;
  logic              unused_rnd;

  ai_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q_o   (rnd)
  );

  // Only the low two bits and one nibble drive decisions.
  assign unused_rnd = ^{rnd[15:8], rnd[3:2]};

  // dx >= 0 means the player is at or left of the enemy, so "toward" is left.
  assign dx      = $signed({enemy_x_i[10], enemy_x_i}) - $signed({player_x_i[10], player_x_i});
  assign adx_raw = dx[11] ? (~$unsigned(dx) + 12'd1) : $unsigned(dx);
  assign adx     = (adx_raw >= ADX_MAX) ? ADX_MAX : adx_raw;

  assign tick       = (dec_cnt_q == DEC_LAST);
  assign threat     = player_atk_i && (adx <= NEAR_C);
  assign aggressive = (rnd[7:4] < AGGRESSION);
  assign dec_cnt_d  = !en_i ? '0 : (tick ? '0 : dec_cnt_q + DEC_W'(1));

  // State, counters and the output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hold_q    <= 8'd0;
      jseen_q   <= 1'b0;
      dec_cnt_q <= '0;
      right_q   <= 1'b0;
      left_q    <= 1'b0;
      jump_q    <= 1'b0;
      squat_q   <= 1'b0;
      defend_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      jseen_q   <= jseen_d;
      dec_cnt_q <= dec_cnt_d;
      right_q   <= right_d;
      left_q    <= left_d;
      jump_q    <= jump_d;
      squat_q   <= squat_d;
      defend_q  <= defend_d;
    end
  end

  // Next-state logic; hold_q is shared by every timed state and cleared on exit.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    jseen_d = jseen_q;
    if (!en_i) begin
      state_d = IDLE;
      hold_d  = 8'd0;
      jseen_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, APPROACH, RETREAT: begin
          if (threat) begin
            hold_d  = 8'd0;
            jseen_d = 1'b0;
            case (rnd[1:0])
              2'd2:    state_d = SQUAT;
              2'd3:    state_d = enemy_isJ_i ? GUARD : JUMP;
              default: state_d = GUARD;
            endcase
          end else if (tick) begin
            if (adx > FAR_C) begin
              state_d = APPROACH;
            end else if (adx < NEAR_C) begin
              state_d = aggressive ? IDLE : RETREAT;
            end else begin
              state_d = aggressive ? APPROACH : IDLE;
            end
          end
        end
        GUARD, SQUAT: begin
          if (hold_q == ((state_q == GUARD) ? GUARD_LAST : SQUAT_LAST)) begin
            state_d = COOLDOWN;
            hold_d  = 8'd0;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
        JUMP: begin
          // Phase 1 waits for lift-off (with timeout), phase 2 for landing.
          if (!jseen_q) begin
            if (enemy_isJ_i) begin
              jseen_d = 1'b1;
            end else if (hold_q == JUMP_LAST) begin
              state_d = COOLDOWN;
              hold_d  = 8'd0;
            end else begin
              hold_d = hold_q + 8'd1;
            end
          end else if (!enemy_isJ_i) begin
            state_d = COOLDOWN;
            hold_d  = 8'd0;
            jseen_d = 1'b0;
          end
        end
        COOLDOWN: begin
          if (hold_q == COOL_LAST) begin
            state_d = IDLE;
            hold_d  = 8'd0;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          hold_d  = 8'd0;
          jseen_d = 1'b0;
        end
      endcase
    end
  end

  // Moore outputs decoded from the next state so they line up with state_q.
  always_comb begin
    right_d  = ((state_d == APPROACH) && dx[11]) || ((state_d == RETREAT) && !dx[11]);
    left_d   = ((state_d == APPROACH) && !dx[11]) || ((state_d == RETREAT) && dx[11]);
    jump_d   = (state_d == JUMP) && (state_q != JUMP);
    squat_d  = (state_d == SQUAT);
    defend_d = (state_d == GUARD);
  end

  assign right_o  = right_q;
  assign left_o   = left_q;
  assign jump_o   = jump_q;
  assign squat_o  = squat_q;
  assign defend_o = defend_q;

endmodule

`default_nettype wire

// File: tb/tb_enemy_ai_ctrl.sv
// ============================================================================
// Module      : tb_enemy_ai_ctrl
// Description : Scoreboard bench for enemy_ai_ctrl. Stimulus process drives
//               inputs on the falling edge and pushes the reference model's
//               expectation; a monitor pops one entry per rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_enemy_ai_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [10:0] px = 11'd0;
  logic [10:0] ex = 11'd0;
  logic        pa = 1'b0;
  logic        isj = 1'b0;
  logic        right_o, left_o, jump_o, squat_o, defend_o;

  always #5 clk = ~clk;

  enemy_ai_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_i         (en),
    .player_x_i   (px),
    .player_atk_i (pa),
    .enemy_x_i    (ex),
    .enemy_isJ_i  (isj),
    .right_o      (right_o),
    .left_o       (left_o),
    .jump_o       (jump_o),
    .squat_o      (squat_o),
    .defend_o     (defend_o)
  );

  typedef struct packed {
    logic        r, l, j, s, d;
    logic [15:0] lf;
  } exp_t;

  typedef enum {M_IDLE, M_APP, M_RET, M_GUARD, M_SQUAT, M_JUMP, M_COOL} mmode_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;

  // Reference model: behaviour described as "mode + cycles left in it".
  mmode_t      mode;
  int          rem;
  int          en_age;
  int          jc;
  bit          seen;
  bit          last_jump;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic logic [10:0] clamp11(input int v);
    if (v > 1023) v = 1023;
    if (v < -1024) v = -1024;
    return 11'(v);
  endfunction

  task automatic model_reset();
    mode = M_IDLE; rem = 0; en_age = 0; jc = 0; seen = 0; last_jump = 0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic push_reset_exp();
    exp_t e;
    e = '0;
    e.lf = 16'hACE1;
    sb.push_back(e);
  endtask

  task automatic model_step();
    int dx, adx;
    logic [15:0] rnd;
    bit tick;
    exp_t e;
    dx  = int'($signed(ex)) - int'($signed(px));
    adx = (dx < 0) ? -dx : dx;
    rnd = m_lfsr;
    last_jump = 0;
    if (!en) begin
      mode = M_IDLE; rem = 0; en_age = 0;
    end else begin
      en_age++;
      tick = (en_age % 8) == 0;
      case (mode)
        M_IDLE, M_APP, M_RET: begin
          if (pa && adx <= 120) begin
            if (rnd[1:0] == 2'd2) begin mode = M_SQUAT; rem = 10; end
            else if (rnd[1:0] == 2'd3 && !isj) begin
              mode = M_JUMP; jc = 0; seen = 0; last_jump = 1;
            end else begin mode = M_GUARD; rem = 12; end
          end else if (tick) begin
            if (adx > 320) mode = M_APP;
            else if (adx < 120) mode = (rnd[7:4] < 4'd8) ? M_IDLE : M_RET;
            else mode = (rnd[7:4] < 4'd8) ? M_APP : M_IDLE;
          end
        end
        M_GUARD, M_SQUAT, M_COOL: begin
          rem--;
          if (rem == 0) begin
            if (mode == M_COOL) mode = M_IDLE;
            else begin mode = M_COOL; rem = 6; end
          end
        end
        default: begin // M_JUMP
          if (!seen && isj) seen = 1;
          else if (seen && !isj) begin mode = M_COOL; rem = 6; end
          else if (!seen && jc == 3) begin mode = M_COOL; rem = 6; end
          jc++;
        end
      endcase
    end
    e.r  = (mode == M_APP && dx < 0) || (mode == M_RET && dx >= 0);
    e.l  = (mode == M_APP && dx >= 0) || (mode == M_RET && dx < 0);
    e.j  = last_jump;
    e.s  = (mode == M_SQUAT);
    e.d  = (mode == M_GUARD);
    m_lfsr = lfsr_step(m_lfsr);
    e.lf = m_lfsr;
    sb.push_back(e);
  endtask

  task automatic step_with(input bit e_v, input logic [10:0] p_v, input logic [10:0] x_v,
                           input bit a_v, input bit j_v);
    @(negedge clk);
    rst_n = 1'b1; en = e_v; px = p_v; ex = x_v; pa = a_v; isj = j_v;
    model_step();
  endtask

  // Reset asserted between edges: outputs must clear without waiting for clk.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({right_o, left_o, jump_o, squat_o, defend_o} !== 5'b0 || dut.u_lfsr.q_o !== 16'hACE1) begin
      miscompares++;
      $display("FAIL async_reset t=%0t got rljsd=%b lfsr=%h required rljsd=00000 lfsr=ace1",
               $time, {right_o, left_o, jump_o, squat_o, defend_o}, dut.u_lfsr.q_o);
    end
    model_reset();
    push_reset_exp();
  endtask

  // Monitor: one expectation per rising edge, plus output-shape properties.
  initial begin : monitor
    exp_t       e;
    logic [4:0] got, want;
    bit         prev_j;
    prev_j = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e    = sb.pop_front();
        got  = {right_o, left_o, jump_o, squat_o, defend_o};
        want = {e.r, e.l, e.j, e.s, e.d};
        vectors++;
        if (got !== want) begin
          miscompares++;
          $display("FAIL outputs t=%0t got rljsd=%b required=%b", $time, got, want);
        end
        vectors++;
        if (dut.u_lfsr.q_o !== e.lf) begin
          miscompares++;
          $display("FAIL lfsr t=%0t got=%h required=%h", $time, dut.u_lfsr.q_o, e.lf);
        end
        vectors++;
        if (right_o && left_o) begin
          miscompares++;
          $display("FAIL right_left_excl t=%0t got r=%b l=%b required not both", $time, right_o, left_o);
        end
        vectors++;
        if ($countones({jump_o, squat_o, defend_o}) > 1) begin
          miscompares++;
          $display("FAIL action_onehot t=%0t got jsd=%b required at most one", $time,
                   {jump_o, squat_o, defend_o});
        end
        vectors++;
        if (prev_j && jump_o) begin
          miscompares++;
          $display("FAIL jump_pulse t=%0t got jump high 2 cycles required 1", $time);
        end
        prev_j = jump_o;
      end
    end
  end

  initial begin : stimulus
    bit isj_now, alt, did_en_drop, did_rst, isj_state;
    int isj_hold, p, off;
    logic [10:0] cur_p, cur_x;
    alt = 0; did_en_drop = 0; did_rst = 0; isj_hold = 0; isj_state = 0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      push_reset_exp();
    end

    // Far apart: first decision tick approaches (left), visible from cycle 9.
    for (int i = 0; i < 20; i++) step_with(1, 11'd100, 11'd600, 0, 0);

    // Mid band both sides of the enemy.
    for (int i = 0; i < 100; i++) step_with(1, 11'd100, 11'd300, 0, 0);
    for (int i = 0; i < 100; i++) step_with(1, 11'd500, 11'd300, 0, 0);

    // Continuous threat in range; jump landings alternate real flight / timeout.
    for (int i = 0; i < 500; i++) begin
      if (!did_en_drop && mode == M_GUARD && rem == 8) begin
        did_en_drop = 1;
        step_with(0, 11'd100, 11'd180, 1, 0);
        step_with(0, 11'd100, 11'd180, 1, 0);
      end
      if (!did_rst && mode == M_SQUAT && rem == 6) begin
        did_rst = 1;
        async_reset();
      end
      isj_now = (isj_hold > 0);
      if (isj_hold > 0) isj_hold--;
      step_with(1, 11'd100, 11'd180, 1, isj_now);
      if (last_jump) begin
        alt = !alt;
        if (alt) isj_hold = 10;
      end
    end

    // Randomized play with en drops, reset pulses, boundaries and extremes.
    cur_p = 11'd0; cur_x = 11'd200;
    for (int i = 0; i < 7000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        p = int'($urandom_range(0, 2047)) - 1024;
        case ($urandom_range(0, 9))
          0, 1, 2, 3: off = int'($urandom_range(0, 240)) - 120;
          4, 5, 6:    off = int'($urandom_range(0, 500)) - 250;
          7:          off = int'($urandom_range(0, 1400)) - 700;
          8: begin p = ($urandom_range(0, 1) != 0) ? -1024 : 1023; off = (p < 0) ? 2047 : -2047; end
          default: begin
            case ($urandom_range(0, 5))
              0: off = 120;  1: off = -120; 2: off = 119;
              3: off = 320;  4: off = -321; default: off = 121;
            endcase
          end
        endcase
        cur_p = clamp11(p);
        cur_x = clamp11(p + off);
      end
      if ($urandom_range(0, 5) == 0) isj_state = !isj_state;
      if ($urandom_range(0, 1999) == 0) async_reset();
      if ($urandom_range(0, 299) == 0) begin
        repeat ($urandom_range(1, 4)) step_with(0, cur_p, cur_x, 0, isj_state);
      end
      step_with(1, cur_p, cur_x, ($urandom_range(0, 3) == 0), isj_state);
    end

    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got=%0d entries left required=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
